pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined add/subtract unit with a valid/ready handshake. It succeeds the fixed 16-bit ripple adder built from 4-bit slices: the operand width is split into SEG_W-bit segments, and one segment is resolved per pipeline stage, with the carry registered between stages. Full throughput is one operation per cycle with back-pressure. It sits in the datapath wherever a wide add or subtract must close timing at the core clock.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of SEG_W.
- SEG_W, 8, segment width resolved per stage. Number of stages L = WIDTH/SEG_W, with L ≥ 1.
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit accepts a beat this cycle.
- num1  input  WIDTH  operand A.
- num2  input  WIDTH  operand B.
- cin  input  1  carry-in (borrow-in when sub=1).
- sub  input  1  0: A+B+cin; 1: A+~B+(~cin), i.e. A−B−cin.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. With sub=1, a value of 1 means no borrow.
- ovf  output  1  signed two's-complement overflow; present only with PIPE_ADDER_OVF_EN.

## Operation
- Effective B = sub ? ~num2 : num2. Effective carry-in = cin ^ sub.
- Stage k (k = 0..L−1) adds segment k of A and effective B plus the carry registered by stage k−1. Stage 0 uses the effective carry-in.
- Each stage register holds:
  - a valid bit;
  - the sum segments resolved so far;
  - the carry;
  - the unresolved upper segments of A and effective B;
  - the MSB signs, when PIPE_ADDER_OVF_EN is defined.
- Global stall: advance = !out_valid | out_ready, and in_ready = advance.
  - When advance is 1, every stage loads from its predecessor. Stage 0 loads from the inputs, with valid set to in_valid & in_ready.
  - When advance is 0, all stages hold.
- Bubbles are not collapsed; an empty stage still occupies a slot.
- Results emerge strictly in acceptance order. No beat is dropped or duplicated.
- sum, cout and ovf are the registered contents of the last stage. They are stable while out_valid=1 and out_ready=0.
- Arithmetic is mod 2^WIDTH. cout is the carry out of bit WIDTH−1. No saturation.
- Reset: all valid bits 0, all data registers 0. out_valid=0, sum=0, cout=0, ovf=0, and in_ready=1 while reset is asserted and afterwards.
- Reset assertion mid-operation discards every in-flight beat immediately. No pre-reset beat ever appears at the output.

## Timing
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+L−1, i.e. it is visible L cycles after acceptance, absent stalls.
- Throughput: one beat per cycle while out_ready=1.
- in_ready depends combinationally on out_valid and out_ready only, never on in_valid.
- With L=1 the block is a single registered adder with the same handshake.
- Simultaneous accept and emit in the same cycle is legal and loses nothing.
- Critical path is one SEG_W-bit add plus the carry mux.

## Configuration
- PIPE_ADDER_OVF_EN:
  - Defined: the ovf port and the sign pipeline exist. ovf = (sA == sBeff) & (sSum != sA), where sA and sBeff are the MSBs of A and effective B, carried alongside the data.
  - Undefined: no ovf port and no sign registers. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=32, SEG_W=8 (L=4) unless stated.
- Carry ripple: num1=0xFFFF_FFFF, num2=1, cin=0, sub=0 → sum=0, cout=1, ovf=0, out_valid exactly 4 cycles after acceptance.
- Subtract: num1=5, num2=7, sub=1, cin=0 → sum=0xFFFF_FFFE, cout=0, ovf=0. Then num1=7, num2=5 → sum=2, cout=1.
- Back-pressure: stream 8 beats (num1=i, num2=i, i=0..7) and hold out_ready=0 for 3 cycles mid-stream → in_ready=0 in those cycles, sum held stable, outputs read 0,2,4,…,14 in order with none missing or duplicated.
- Reset mid-stream: 3 beats in flight, pulse rst_n low asynchronously between edges → out_valid and sum go to 0 at once. After release, out_valid stays 0 until new beats arrive.
- Overflow (macro defined): 0x7FFF_FFFF+1 → ovf=1, sum=0x8000_0000. 0x8000_0000−1 with sub=1 → ovf=1. Macro undefined: the design elaborates without the ovf port.
- Degenerate config WIDTH=16, SEG_W=16 (L=1): 1000 random beats with random out_ready → every result matches the reference arithmetic, with one-cycle latency.

Source files
------------

// File: rtl/pipelined_adder_if.sv
// Handshake/data bundle for pipelined_adder.
// The ovf signal exists only when PIPE_ADDER_OVF_EN is defined.
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPE_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, num1, num2, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, num1, num2, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, num1, num2, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, num1, num2, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract, one SEG_W-bit segment resolved per stage, global-stall handshake.
// Optional signed overflow output and sign pipeline: define PIPE_ADDER_OVF_EN.
module pipelined_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_adder_if.slave  bus
);
  localparam int unsigned L = WIDTH / SEG_W;

  typedef logic [SEG_W:0] seg_t;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Per-stage registers: a_rem/b_rem hold the still-unresolved upper segments,
  // shifted down so the next stage always consumes bits [SEG_W-1:0].
  logic [L-1:0]     vld;
  logic [L-1:0]     cy;
  logic [WIDTH-1:0] acc   [L];
  logic [WIDTH-1:0] a_rem [L];
  logic [WIDTH-1:0] b_rem [L];

  logic [L-1:0]     vld_src;
  logic [L-1:0]     cin_src;
  logic [WIDTH-1:0] acc_src [L];
  logic [WIDTH-1:0] a_src   [L];
  logic [WIDTH-1:0] b_src   [L];
  seg_t             seg     [L];

`ifdef PIPE_ADDER_OVF_EN
  logic [L-1:0]     sa;
  logic [L-1:0]     sb;
  logic [L-1:0]     sa_src;
  logic [L-1:0]     sb_src;
`endif

  always_comb begin
    advance = !vld[L-1] | bus.out_ready;
    b_eff   = bus.sub ? ~bus.num2 : bus.num2;
    c_eff   = bus.cin ^ bus.sub;
  end

  // Source of stage k is the inputs for k=0 and register k-1 otherwise.
  always_comb begin
    vld_src    = '0;
    cin_src    = '0;
    vld_src[0] = bus.in_valid & advance;
    cin_src[0] = c_eff;
    acc_src[0] = '0;
    a_src[0]   = bus.num1;
    b_src[0]   = b_eff;
`ifdef PIPE_ADDER_OVF_EN
    sa_src    = '0;
    sb_src    = '0;
    sa_src[0] = bus.num1[WIDTH-1];
    sb_src[0] = b_eff[WIDTH-1];
`endif
    for (int unsigned k = 1; k < L; k++) begin
      vld_src[k] = vld[k-1];
      cin_src[k] = cy[k-1];
      acc_src[k] = acc[k-1];
      a_src[k]   = a_rem[k-1];
      b_src[k]   = b_rem[k-1];
`ifdef PIPE_ADDER_OVF_EN
      sa_src[k]  = sa[k-1];
      sb_src[k]  = sb[k-1];
`endif
    end
    for (int unsigned k = 0; k < L; k++) begin
      seg[k] = seg_t'(a_src[k][SEG_W-1:0]) + seg_t'(b_src[k][SEG_W-1:0]) + seg_t'(cin_src[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      cy  <= '0;
      for (int unsigned k = 0; k < L; k++) begin
        acc[k]   <= '0;
        a_rem[k] <= '0;
        b_rem[k] <= '0;
      end
`ifdef PIPE_ADDER_OVF_EN
      sa <= '0;
      sb <= '0;
`endif
    end else if (advance) begin
      for (int unsigned k = 0; k < L; k++) begin
        vld[k]   <= vld_src[k];
        cy[k]    <= seg[k][SEG_W];
        acc[k]   <= acc_src[k] | (WIDTH'(seg[k][SEG_W-1:0]) << (k * SEG_W));
        a_rem[k] <= a_src[k] >> SEG_W;
        b_rem[k] <= b_src[k] >> SEG_W;
      end
`ifdef PIPE_ADDER_OVF_EN
      sa <= sa_src;
      sb <= sb_src;
`endif
    end
  end

  always_comb begin
    bus.in_ready  = advance;
    bus.out_valid = vld[L-1];
    bus.sum       = acc[L-1];
    bus.cout      = cy[L-1];
`ifdef PIPE_ADDER_OVF_EN
    bus.ovf       = (sa[L-1] == sb[L-1]) & (acc[L-1][WIDTH-1] != sa[L-1]);
`endif
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: L=4 (32/8) and L=1 (16/16) instances against an arithmetic reference.
// Overflow checks are active when PIPE_ADDER_OVF_EN is defined.
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(32)) b4 ();
  pipelined_adder_if #(.WIDTH(16)) b1 ();

  pipelined_adder #(.WIDTH(32), .SEG_W(8))  dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  pipelined_adder #(.WIDTH(16), .SEG_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  int n_checks = 0;
  int n_errors = 0;

  typedef logic [65:0] exp_t;  // {ovf, cout, sum}
  exp_t        q4[$];
  exp_t        q1[$];
  logic [31:0] seen4[$];
  logic        record_seen = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic exp_t ref_op(int unsigned w, logic [31:0] a, logic [31:0] b, logic c, logic s);
    longint unsigned m, ua, ub, full;
    longint sa, sb, st, lc;
    logic ovf;
    m  = 64'd1 << w;
    ua = {32'b0, a} & (m - 1);
    ub = {32'b0, b} & (m - 1);
    lc = c ? 1 : 0;
    full = s ? (m + ua - ub - longint'(lc)) : (ua + ub + longint'(lc));
    sa = (ua >= m / 2) ? longint'(ua) - longint'(m) : longint'(ua);
    sb = (ub >= m / 2) ? longint'(ub) - longint'(m) : longint'(ub);
    st = s ? sa - sb - lc : sa + sb + lc;
    ovf = (st > longint'(m / 2) - 1) || (st < -longint'(m / 2));
    return {ovf, full[w], full & (m - 1)};
  endfunction

  // Monitor for the 4-stage instance
  logic        stall4_prev = 1'b0;
  logic [31:0] sum4_prev;
  logic        cout4_prev;
  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_n) begin
      check("in_ready4", b4.in_ready, !b4.out_valid || b4.out_ready);
      if (stall4_prev) begin
        check("hold_valid4", b4.out_valid, 1);
        check("hold_sum4", b4.sum, sum4_prev);
        check("hold_cout4", b4.cout, cout4_prev);
      end
      stall4_prev = b4.out_valid && !b4.out_ready;
      sum4_prev   = b4.sum;
      cout4_prev  = b4.cout;
      if (b4.out_valid && b4.out_ready) begin
        check("beat_expected4", q4.size() > 0, 1);
        if (q4.size() > 0) begin
          e = q4.pop_front();
          check("sum4", b4.sum, e[31:0]);
          check("cout4", b4.cout, e[64]);
`ifdef PIPE_ADDER_OVF_EN
          check("ovf4", b4.ovf, e[65]);
`endif
          if (record_seen) seen4.push_back(b4.sum);
        end
      end
      if (b4.in_valid && b4.in_ready)
        q4.push_back(ref_op(32, b4.num1, b4.num2, b4.cin, b4.sub));
    end else begin
      stall4_prev = 1'b0;
    end
  end

  // Monitor for the single-stage instance
  logic        stall1_prev = 1'b0;
  logic        acc1_prev   = 1'b0;
  logic [15:0] sum1_prev;
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n) begin
      if (acc1_prev) check("lat1", b1.out_valid, 1);
      if (stall1_prev) begin
        check("hold_valid1", b1.out_valid, 1);
        check("hold_sum1", b1.sum, sum1_prev);
      end
      stall1_prev = b1.out_valid && !b1.out_ready;
      sum1_prev   = b1.sum;
      if (b1.out_valid && b1.out_ready) begin
        check("beat_expected1", q1.size() > 0, 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          check("sum1", b1.sum, e[15:0]);
          check("cout1", b1.cout, e[64]);
`ifdef PIPE_ADDER_OVF_EN
          check("ovf1", b1.ovf, e[65]);
`endif
        end
      end
      acc1_prev = b1.in_valid && b1.in_ready;
      if (acc1_prev)
        q1.push_back(ref_op(16, {16'b0, b1.num1}, {16'b0, b1.num2}, b1.cin, b1.sub));
    end else begin
      stall1_prev = 1'b0;
      acc1_prev   = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single beat into the 4-stage unit (out_ready held 1 by caller).
  task automatic send4(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    b4.num1 = a; b4.num2 = b; b4.cin = c; b4.sub = s;
    b4.in_valid = 1'b1;
    tick();
    b4.in_valid = 1'b0;
  endtask

  // Count negedges until out_valid, bounded.
  task automatic await4(output int cnt);
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (b4.out_valid) break;
    end
    check("await4_timeout", cnt < 20, 1);
  endtask

  logic [31:0] pick32;
  function automatic logic [31:0] corner32(int unsigned sel);
    case (sel)
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int cnt;
    int beat;
    b4.in_valid = 1'b0; b4.num1 = '0; b4.num2 = '0; b4.cin = 1'b0; b4.sub = 1'b0; b4.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.num1 = '0; b1.num2 = '0; b1.cin = 1'b0; b1.sub = 1'b0; b1.out_ready = 1'b1;

    #1;
    check("rst_out_valid", b4.out_valid, 0);
    check("rst_sum", b4.sum, 0);
    check("rst_cout", b4.cout, 0);
    check("rst_in_ready", b4.in_ready, 1);
`ifdef PIPE_ADDER_OVF_EN
    check("rst_ovf", b4.ovf, 0);
`endif
    #11 rst_n = 1'b1;
    tick();

    // Carry ripple through all four segments
    send4(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    await4(cnt);
    check("ripple_latency", cnt, 4);
    check("ripple_sum", b4.sum, 0);
    check("ripple_cout", b4.cout, 1);
`ifdef PIPE_ADDER_OVF_EN
    check("ripple_ovf", b4.ovf, 0);
`endif
    tick();

    send4(32'd5, 32'd7, 1'b0, 1'b1);
    await4(cnt);
    check("sub_neg_sum", b4.sum, 32'hFFFF_FFFE);
    check("sub_neg_cout", b4.cout, 0);
`ifdef PIPE_ADDER_OVF_EN
    check("sub_neg_ovf", b4.ovf, 0);
`endif
    tick();
    send4(32'd7, 32'd5, 1'b0, 1'b1);
    await4(cnt);
    check("sub_pos_sum", b4.sum, 32'd2);
    check("sub_pos_cout", b4.cout, 1);
    tick();

`ifdef PIPE_ADDER_OVF_EN
    send4(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    await4(cnt);
    check("ovf_add_sum", b4.sum, 32'h8000_0000);
    check("ovf_add", b4.ovf, 1);
    tick();
    send4(32'h8000_0000, 32'd1, 1'b0, 1'b1);
    await4(cnt);
    check("ovf_sub_sum", b4.sum, 32'h7FFF_FFFF);
    check("ovf_sub", b4.ovf, 1);
    tick();
`endif

    // Back-pressure: 8 beats, three stalled cycles mid-stream
    seen4.delete();
    record_seen = 1'b1;
    beat = 0;
    for (int t = 0; t < 24; t++) begin
      b4.in_valid  = (beat < 8);
      b4.num1      = beat;
      b4.num2      = beat;
      b4.cin       = 1'b0;
      b4.sub       = 1'b0;
      b4.out_ready = !(t >= 6 && t < 9);
      @(negedge clk);
      if (!b4.out_ready && b4.out_valid) check("bp_in_ready", b4.in_ready, 0);
      if (b4.in_valid && b4.in_ready) beat++;
      tick();
    end
    b4.in_valid  = 1'b0;
    b4.out_ready = 1'b1;
    record_seen  = 1'b0;
    check("bp_count", seen4.size(), 8);
    for (int k = 0; k < 8 && k < seen4.size(); k++) check("bp_order", seen4[k], 2 * k);

    // Reset mid-stream with beats in flight and one at the output
    for (int i = 0; i < 3; i++) send4(32'd100 + i, 32'd1, 1'b0, 1'b0);
    tick();
    check("pre_rst_valid", b4.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", b4.out_valid, 0);
    check("midrst_sum", b4.sum, 0);
    check("midrst_cout", b4.cout, 0);
    check("midrst_in_ready", b4.in_ready, 1);
    q4.delete();
    q1.delete();
    tick();
    tick();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("postrst_idle", b4.out_valid, 0);
    end
    tick();

    // Random traffic on the 4-stage unit
    for (int i = 0; i < 400; i++) begin
      b4.in_valid  = ($urandom_range(0, 3) != 0);
      b4.out_ready = ($urandom_range(0, 3) != 0);
      b4.num1      = corner32($urandom_range(0, 7));
      b4.num2      = corner32($urandom_range(0, 7));
      b4.cin       = 1'($urandom_range(0, 1));
      b4.sub       = 1'($urandom_range(0, 1));
      tick();
    end
    b4.in_valid  = 1'b0;
    b4.out_ready = 1'b1;
    for (int i = 0; i < 20 && (q4.size() > 0 || b4.out_valid); i++) tick();
    check("drain4", q4.size(), 0);

    // Random traffic on the single-stage unit
    for (int i = 0; i < 1000; i++) begin
      b1.in_valid  = ($urandom_range(0, 3) != 0);
      b1.out_ready = ($urandom_range(0, 2) != 0);
      pick32       = corner32($urandom_range(0, 7));
      b1.num1      = pick32[31:16];
      pick32       = corner32($urandom_range(0, 7));
      b1.num2      = pick32[15:0];
      b1.cin       = 1'($urandom_range(0, 1));
      b1.sub       = 1'($urandom_range(0, 1));
      tick();
    end
    b1.in_valid  = 1'b0;
    b1.out_ready = 1'b1;
    for (int i = 0; i < 10 && (q1.size() > 0 || b1.out_valid); i++) tick();
    check("drain1", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
